// File: rtl/std_mem_burst_pkg.sv
// Shared types for the burst reader: FSM state encoding and id tag position.
// Latency: n/a (types only).
// Backpressure: n/a.
package std_mem_burst_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    localparam int LAST_TAG_BIT = 0;

endpackage

// File: rtl/std_mem_intf.sv
// Single-port memory command/result channel with valid/ready handshake.
// Latency: n/a (wires only).
// Backpressure: producer holds valid and payload until ready is seen high.
interface std_mem_intf #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 1
);
    logic                  valid;
    logic                  ready;
    logic                  read_enable;
    logic                  write_enable;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic [ID_WIDTH-1:0]   id;

    modport out (output valid, read_enable, write_enable, addr, data, id, input ready);
    modport in  (input valid, data, id, output ready);
endinterface

// File: rtl/std_mem_burst_reader.sv
// Burst reader: turns one (addr, len) request into sequential memory reads; STD_MEM_BURST_STRIDE_EN adds req_stride.
// Latency: first command one cycle after request accept; read data is passed through combinationally.
// Backpressure: out_ready drives result.ready directly; issue stalls while MAX_OUTSTANDING reads are unconsumed.
module std_mem_burst_reader
    import std_mem_burst_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int LEN_WIDTH       = 16,
    parameter int ADDR_STEP       = 1,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [LEN_WIDTH-1:0]  req_len,
`ifdef STD_MEM_BURST_STRIDE_EN
    input  logic [ADDR_WIDTH-1:0] req_stride,
`endif
    std_mem_intf.out              command,
    std_mem_intf.in               result,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  done
);

    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUTSTANDING);

    state_t                 state;
    logic [ADDR_WIDTH-1:0]  addr;
    logic [ADDR_WIDTH-1:0]  step;
    logic [LEN_WIDTH-1:0]   remaining;
    logic [OUT_W-1:0]       outstanding;
    logic [OUT_W-1:0]       out_next;
    logic                   cmd_valid;
    logic                   cmd_fire;
    logic                   res_fire;
    logic                   last_cmd;

`ifdef STD_MEM_BURST_STRIDE_EN
    logic [ADDR_WIDTH-1:0]  stride;
    assign step = stride;
`else
    assign step = ADDR_WIDTH'(ADDR_STEP);
`endif

    assign cmd_fire = cmd_valid && command.ready;
    assign res_fire = result.valid && out_ready;
    assign last_cmd = (remaining == LEN_WIDTH'(1));

    always_comb begin
        out_next = outstanding;
        case ({cmd_fire, res_fire})
            2'b10:   out_next = outstanding + OUT_W'(1);
            2'b01:   out_next = outstanding - OUT_W'(1);
            default: out_next = outstanding;
        endcase
    end

    // Issue gating is credit based: cmd_valid is precomputed from next-cycle outstanding,
    // so once raised it cannot drop before the command is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            outstanding <= '0;
            cmd_valid   <= 1'b0;
            done        <= 1'b0;
        end else begin
            outstanding <= out_next;
            done        <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr      <= req_addr;
                        remaining <= req_len;
`ifdef STD_MEM_BURST_STRIDE_EN
                        stride    <= req_stride;
`endif
                        if (req_len == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state     <= ISSUE;
                            cmd_valid <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (cmd_fire) begin
                        addr      <= addr + step;
                        remaining <= remaining - LEN_WIDTH'(1);
                    end
                    if (cmd_fire && last_cmd) begin
                        state     <= DRAIN;
                        cmd_valid <= 1'b0;
                    end else begin
                        cmd_valid <= (out_next < OUT_MAX);
                    end
                end
                DRAIN: begin
                    if (out_next == '0) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready = (state == IDLE) && !rst;

    assign command.valid        = cmd_valid;
    assign command.read_enable  = 1'b1;
    assign command.write_enable = 1'b0;
    assign command.addr         = addr;
    assign command.data         = '0;

    always_comb begin
        command.id               = '0;
        command.id[LAST_TAG_BIT] = last_cmd;
    end

    assign out_valid    = result.valid;
    assign out_data     = result.data;
    assign out_last     = result.id[LAST_TAG_BIT];
    assign result.ready = out_ready;

    result_needs_outstanding: assert property (@(posedge clk) disable iff (rst)
        result.valid |-> (outstanding != '0));

endmodule

// File: tb/tb_std_mem_burst_reader.sv
// Bench for std_mem_burst_reader: randomized bursts against a queue-based memory and scoreboard.
module tb_std_mem_burst_reader;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int LW   = 16;
    localparam int STEP = 1;
    localparam int MAXO = 2;
    localparam int IDW  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic [LW-1:0] req_len;
`ifdef STD_MEM_BURST_STRIDE_EN
    logic [AW-1:0] req_stride;
`endif
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          done;

    std_mem_intf #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IDW)) cmd_if ();
    std_mem_intf #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IDW)) res_if ();

    std_mem_burst_reader #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW),
        .ADDR_STEP(STEP), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_len   (req_len),
`ifdef STD_MEM_BURST_STRIDE_EN
        .req_stride(req_stride),
`endif
        .command   (cmd_if),
        .result    (res_if),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .done      (done)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic          last;
    } cmd_t;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    cmd_t          exp_cmd[$];
    beat_t         exp_beat[$];
    int            exp_done[$];
    int            fire_cyc[$];
    logic [AW-1:0] mem_addr_q[$];
    logic [IDW-1:0] mem_id_q[$];

    int   cmd_rdy_mode = 1;   // 0 random, 1 high, 2 low
    int   out_rdy_mode = 1;
    int   tb_out       = 0;
    int   max_seen     = 0;
    logic res_hold     = 1'b0;
    logic prev_stall   = 1'b0;
    logic [AW-1:0]  prev_addr;
    logic [IDW-1:0] prev_id;

    function automatic logic [DW-1:0] mem_data(input logic [AW-1:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        compared++;
        if (act !== want) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // Memory and downstream-ready driver, one step after each rising edge.
    always begin
        @(posedge clk);
        #1;
        cmd_if.ready = (cmd_rdy_mode == 0) ? ($urandom_range(0, 3) != 0) : (cmd_rdy_mode == 1);
        out_ready    = (out_rdy_mode == 0) ? ($urandom_range(0, 3) != 0) : (out_rdy_mode == 1);
        if (!rst && mem_addr_q.size() > 0 &&
            (cmd_rdy_mode != 0 || res_hold || $urandom_range(0, 2) != 0)) begin
            res_if.valid = 1'b1;
            res_if.data  = mem_data(mem_addr_q[0]);
            res_if.id    = mem_id_q[0];
        end else begin
            res_if.valid = 1'b0;
            res_if.data  = '0;
            res_if.id    = '0;
        end
    end

    // Memory bookkeeping: accepted commands queue up, results retire from the head.
    always begin
        @(negedge clk);
        if (rst) begin
            mem_addr_q.delete();
            mem_id_q.delete();
            res_hold = 1'b0;
        end else begin
            if (cmd_if.valid && cmd_if.ready) begin
                mem_addr_q.push_back(cmd_if.addr);
                mem_id_q.push_back(cmd_if.id);
            end
            if (res_if.valid && res_if.ready) begin
                void'(mem_addr_q.pop_front());
                void'(mem_id_q.pop_front());
            end
            res_hold = res_if.valid && !res_if.ready;
        end
    end

    // Monitor: compares every command, output beat and done pulse against the scoreboard.
    always begin
        cmd_t  ec;
        beat_t eb;
        logic  want_done;
        @(negedge clk);
        if (rst) begin
            tb_out     = 0;
            prev_stall = 1'b0;
        end else begin
            if (tb_out == MAXO) check("cmd_valid_at_max", cmd_if.valid, 0);
            if (prev_stall) begin
                check("cmd_hold_valid", cmd_if.valid, 1);
                check("cmd_hold_addr", cmd_if.addr, prev_addr);
                check("cmd_hold_id", cmd_if.id, prev_id);
            end
            prev_stall = cmd_if.valid && !cmd_if.ready;
            prev_addr  = cmd_if.addr;
            prev_id    = cmd_if.id;

            if (cmd_if.valid && cmd_if.ready) begin
                fire_cyc.push_back(cyc);
                tb_out++;
                if (exp_cmd.size() == 0) begin
                    check("unexpected_cmd", cmd_if.addr, 64'hDEAD);
                end else begin
                    ec = exp_cmd.pop_front();
                    check("cmd_addr", cmd_if.addr, ec.addr);
                    check("cmd_last_tag", cmd_if.id[0], ec.last);
                    check("cmd_id_upper", cmd_if.id[IDW-1:1], 0);
                    check("cmd_rw", {cmd_if.read_enable, cmd_if.write_enable}, 2'b10);
                    check("cmd_data", cmd_if.data, 0);
                end
            end

            if (out_valid && out_ready) begin
                tb_out--;
                if (exp_beat.size() == 0) begin
                    check("unexpected_beat", out_data, 64'hDEAD);
                end else begin
                    eb = exp_beat.pop_front();
                    check("out_data", out_data, eb.data);
                    check("out_last", out_last, eb.last);
                    if (eb.last) exp_done.push_back(cyc + 1);
                end
            end
            if (cmd_if.valid && cmd_if.ready) check("outstanding_limit", tb_out <= MAXO, 1);
            if (tb_out > max_seen) max_seen = tb_out;

            want_done = (exp_done.size() > 0) && (exp_done[0] == cyc);
            if (want_done || done) check("done_pulse", done, want_done);
            if (want_done) void'(exp_done.pop_front());
        end
    end

    // Called one step after a rising edge; returns one step after the edge following acceptance.
    task automatic run_burst(input logic [AW-1:0] a, input int n, input logic [AW-1:0] s);
        logic [AW-1:0] ad;
        bit            acc;
        int            budget;
        req_addr  = a;
        req_len   = LW'(n);
`ifdef STD_MEM_BURST_STRIDE_EN
        req_stride = s;
`endif
        req_valid = 1'b1;
        acc       = 1'b0;
        budget    = 0;
        while (!acc && budget < 50) begin
            @(negedge clk);
            if (req_ready) begin
                acc = 1'b1;
                ad  = a;
                for (int i = 0; i < n; i++) begin
                    exp_cmd.push_back('{addr: ad, last: (i == n - 1)});
                    exp_beat.push_back('{data: mem_data(ad), last: (i == n - 1)});
                    ad = ad + s;
                end
                if (n == 0) exp_done.push_back(cyc + 1);
            end else begin
                budget++;
            end
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        if (!acc) check("req_accept_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        int b;
        for (b = 0; b < 3000; b++) begin
            @(negedge clk);
            if (exp_cmd.size() == 0 && exp_beat.size() == 0 && exp_done.size() == 0) break;
        end
        if (b >= 3000) begin
            check("burst_drain_timeout", b, 0);
            exp_cmd.delete();
            exp_beat.delete();
            exp_done.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [AW-1:0] ra;
        logic [AW-1:0] rs;
        rst = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        req_len   = '0;
`ifdef STD_MEM_BURST_STRIDE_EN
        req_stride = '0;
`endif
        out_ready           = 1'b0;
        cmd_if.ready        = 1'b0;
        res_if.valid        = 1'b0;
        res_if.data         = '0;
        res_if.id           = '0;
        res_if.addr         = '0;
        res_if.read_enable  = 1'b0;
        res_if.write_enable = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", req_ready, 0);
        check("rst_cmd_valid", cmd_if.valid, 0);
        check("rst_done", done, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("idle_req_ready", req_ready, 1);
        @(posedge clk);
        #1;

        // Four-beat burst, everything always ready: commands back to back.
        fire_cyc.delete();
        run_burst(32'h10, 4, AW'(STEP));
        wait_idle();
        check("b2b_fire_count", fire_cyc.size(), 4);
        if (fire_cyc.size() == 4) check("b2b_fire_span", fire_cyc[3] - fire_cyc[0], 3);

        // Zero-length burst.
        run_burst(32'h40, 0, AW'(STEP));
        @(negedge clk);
        check("len0_req_ready_in_done", req_ready, 0);
        check("len0_no_cmd", cmd_if.valid, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("len0_req_ready_after", req_ready, 1);
        check("len0_no_out", out_valid, 0);
        @(posedge clk);
        #1;
        wait_idle();

        // Downstream stall mid-burst: issue must stop at MAXO in flight.
        max_seen = 0;
        run_burst(32'h100, 8, AW'(STEP));
        @(negedge clk);
        out_rdy_mode = 2;
        repeat (10) @(negedge clk);
        out_rdy_mode = 1;
        @(posedge clk);
        #1;
        wait_idle();
        check("stall_max_outstanding", max_seen, MAXO);

        // Address wrap at the top of the address space.
        run_burst(32'hFFFF_FFFF, 2, AW'(STEP));
        wait_idle();

`ifdef STD_MEM_BURST_STRIDE_EN
        run_burst(32'h0, 3, 32'd4);
        wait_idle();
        run_burst(32'h0, 3, 32'd0);
        wait_idle();
`endif

        // Randomized bursts with random memory and downstream backpressure.
        cmd_rdy_mode = 0;
        out_rdy_mode = 0;
        for (int k = 0; k < 25; k++) begin
            ra = $urandom;
`ifdef STD_MEM_BURST_STRIDE_EN
            rs = ($urandom_range(0, 2) == 0) ? AW'($urandom_range(0, 8)) : $urandom;
`else
            rs = AW'(STEP);
`endif
            run_burst(ra, $urandom_range(0, 12), rs);
            wait_idle();
        end

        // Reset with one read in flight, then a fresh single-beat burst.
        @(negedge clk);
        cmd_rdy_mode = 1;
        out_rdy_mode = 2;
        @(posedge clk);
        #1;
        run_burst(32'h200, 6, AW'(STEP));
        @(negedge clk);
        cmd_rdy_mode = 2;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_cmd.delete();
        exp_beat.delete();
        exp_done.delete();
        cmd_rdy_mode = 1;
        out_rdy_mode = 1;
        @(negedge clk);
        check("post_rst_req_ready", req_ready, 1);
        check("post_rst_cmd_valid", cmd_if.valid, 0);
        check("post_rst_done", done, 0);
        @(posedge clk);
        #1;
        run_burst(32'h300, 1, AW'(STEP));
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
